ascon_data_padder: RTL and testbench

Upstream packing stage for the ASCON-128 datapath. It accepts associated-data or plaintext bytes over a valid/ready stream and packs them big-endian into 64-bit rate blocks. It applies ASCON 10* padding to the final block and presents each block, with last-block and byte-count tags, to the controller. The controller forwards the block as `data_i` of the permutation-entry XOR stage, asserting `xor_data_i` for that permutation.

---
 rtl/ascon_data_padder.sv | 111 +++++++++++
 tb/tb_ascon_data_padder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_data_padder.sv
// ascon_data_padder: packs a byte stream big-endian into 64-bit ASCON rate blocks with 10* padding
module ascon_data_padder (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  input  logic        pad_only_i,
  output logic [63:0] block_o,
  output logic        block_valid_o,
  input  logic        block_ready_i,
  output logic        block_last_o,
  output logic [3:0]  block_nbytes_o
);
  typedef enum logic [1:0] {S_FILL, S_OUT, S_PADX} state_t;
  localparam logic [63:0] c_pad = 64'h8000_0000_0000_0000;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [63:0] r_pack;
  logic        r_pad_pend;
  logic [63:0] r_block;
  logic        r_valid;
  logic        r_last;
  logic [3:0]  r_nbytes;
  logic        w_acc;
  logic [3:0]  w_n;
  logic        w_full;
  logic [63:0] w_packed;
  logic [63:0] w_pad;
  assign byte_ready_o   = r_state == S_FILL;
  assign block_o        = r_block;
  assign block_valid_o  = r_valid;
  assign block_last_o   = r_last;
  assign block_nbytes_o = r_nbytes;
  // next-byte placement and the 0x80 marker that follows the new byte count (zero once the block is full)
  always_comb begin
    w_acc    = byte_valid_i & byte_ready_o;
    w_n      = {1'b0, r_cnt} + 4'd1;
    w_full   = w_n[3];
    w_packed = r_pack | ({byte_i, 56'd0} >> {r_cnt, 3'b000});
    w_pad    = c_pad >> {w_n, 3'b000};
  end
  // fill / output / extra-pad sequencing with registered block and tags
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state    <= S_FILL;
      r_cnt      <= 3'd0;
      r_pack     <= 64'd0;
      r_pad_pend <= 1'b0;
      r_block    <= 64'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_nbytes   <= 4'd0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_acc) begin
            if (byte_last_i || w_full) begin
              r_block    <= w_packed | w_pad;
              r_last     <= byte_last_i & ~w_full;
              r_nbytes   <= w_n;
              r_pad_pend <= byte_last_i & w_full;
              r_valid    <= 1'b1;
              r_cnt      <= 3'd0;
              r_pack     <= 64'd0;
              r_state    <= S_OUT;
            end else begin
              r_pack <= w_packed;
              r_cnt  <= w_n[2:0];
            end
          end else if (pad_only_i && r_cnt == 3'd0) begin
            r_block  <= c_pad;
            r_last   <= 1'b1;
            r_nbytes <= 4'd0;
            r_valid  <= 1'b1;
            r_state  <= S_OUT;
          end
        end
        S_OUT: begin
          if (block_ready_i) begin
            if (r_pad_pend) begin
              r_block  <= c_pad;
              r_last   <= 1'b1;
              r_nbytes <= 4'd0;
              r_state  <= S_PADX;
            end else begin
              r_block  <= 64'd0;
              r_last   <= 1'b0;
              r_nbytes <= 4'd0;
              r_valid  <= 1'b0;
              r_pack   <= 64'd0;
              r_state  <= S_FILL;
            end
          end
        end
        S_PADX: begin
          if (block_ready_i) begin
            r_block    <= 64'd0;
            r_last     <= 1'b0;
            r_nbytes   <= 4'd0;
            r_valid    <= 1'b0;
            r_pad_pend <= 1'b0;
            r_state    <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_data_padder.sv
// tb_ascon_data_padder: directed and random streams checked against a chunk-and-pad reference model
module tb_ascon_data_padder;
  logic        clock_i = 1'b0;
  logic        resetb_i = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_last_i = 1'b0;
  logic        byte_ready_o;
  logic        pad_only_i = 1'b0;
  logic [63:0] block_o;
  logic        block_valid_o;
  logic        block_ready_i = 1'b0;
  logic        block_last_o;
  logic [3:0]  block_nbytes_o;
  typedef struct {logic [63:0] d; logic last; logic [3:0] n;} blk_t;
  blk_t exp_q[$];
  int pass_n = 0;
  int fail_n = 0;
  int total_n = 0;
  int fill = 0;
  ascon_data_padder dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_last_i(byte_last_i), .byte_ready_o(byte_ready_o), .pad_only_i(pad_only_i),
    .block_o(block_o), .block_valid_o(block_valid_o), .block_ready_i(block_ready_i),
    .block_last_o(block_last_o), .block_nbytes_o(block_nbytes_o)
  );
  always #5 clock_i = ~clock_i;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total_n++;
    assert (o === e) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  // a stream of L bytes becomes floor(L/8) full blocks plus one final block of the remaining r bytes, 0x80, zeros
  task automatic model(input logic [7:0] s[$]);
    int full;
    int r;
    logic [63:0] d;
    full = s.size() / 8;
    r = s.size() % 8;
    for (int b = 0; b < full; b++) begin
      d = 0;
      for (int i = 0; i < 8; i++) d = d * 256 + 64'(s[8*b+i]);
      exp_q.push_back('{d, 1'b0, 4'd8});
    end
    d = 0;
    for (int i = 0; i < 8; i++) d = d * 256 + (i < r ? 64'(s[8*full+i]) : (i == r ? 64'h80 : 64'h0));
    exp_q.push_back('{d, 1'b1, 4'(r)});
  endtask
  task automatic consume(input int stall);
    blk_t e;
    chk("exp_avail", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("valid", block_valid_o, 1);
    chk("data", block_o, e.d);
    chk("last", block_last_o, e.last);
    chk("nbytes", block_nbytes_o, e.n);
    chk("ready_low", byte_ready_o, 0);
    for (int k = 0; k < stall; k++) begin
      byte_valid_i = 1'b1;
      byte_i = 8'hEE;
      @(posedge clock_i); #1;
      chk("stall_valid", block_valid_o, 1);
      chk("stall_data", block_o, e.d);
      chk("stall_last", block_last_o, e.last);
      chk("stall_nbytes", block_nbytes_o, e.n);
      chk("stall_ready_low", byte_ready_o, 0);
    end
    block_ready_i = 1'b1;
    @(posedge clock_i); #1;
    block_ready_i = 1'b0;
    byte_valid_i = 1'b0;
  endtask
  task automatic idle_chk();
    chk("idle_ready", byte_ready_o, 1);
    chk("idle_valid", block_valid_o, 0);
    chk("idle_data", block_o, 0);
  endtask
  task automatic send(input logic [7:0] s[$], input bit term, input bit drain, input int stall, input bit po);
    bit lb;
    for (int i = 0; i < s.size(); i++) begin
      lb = term && (i == s.size() - 1);
      byte_i = s[i];
      byte_valid_i = 1'b1;
      byte_last_i = lb;
      pad_only_i = po && (i == 0);
      @(posedge clock_i); #1;
      byte_valid_i = 1'b0;
      byte_last_i = 1'b0;
      pad_only_i = 1'b0;
      fill++;
      chk("valid_latency", block_valid_o, 64'(fill == 8 || lb));
      if (fill == 8 || lb) begin
        fill = 0;
        if (!lb || drain) consume(stall);
        if (lb && drain) while (exp_q.size() > 0) consume(stall);
      end
    end
    if (term && drain) idle_chk();
  endtask
  task automatic pad_pulse();
    pad_only_i = 1'b1;
    @(posedge clock_i); #1;
    pad_only_i = 1'b0;
  endtask
  task automatic do_reset();
    resetb_i = 1'b0;
    #2;
    chk("rst_data", block_o, 0);
    chk("rst_valid", block_valid_o, 0);
    chk("rst_last", block_last_o, 0);
    chk("rst_nbytes", block_nbytes_o, 0);
    @(posedge clock_i); #1;
    resetb_i = 1'b1;
    fill = 0;
    exp_q.delete();
    idle_chk();
  endtask
  initial begin
    logic [7:0] q[$];
    logic [7:0] q2[$];
    int len;
    #2;
    chk("por_data", block_o, 0);
    chk("por_valid", block_valid_o, 0);
    chk("por_last", block_last_o, 0);
    chk("por_nbytes", block_nbytes_o, 0);
    repeat (2) @(posedge clock_i);
    #1;
    resetb_i = 1'b1;
    idle_chk();
    q.delete();
    for (int i = 1; i <= 3; i++) q.push_back(8'(i));
    model(q);
    send(q, 1, 1, 0, 0);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'(i));
    model(q);
    send(q, 1, 1, 1, 0);
    q.delete();
    for (int i = 16; i <= 26; i++) q.push_back(8'(i));
    model(q);
    send(q, 1, 1, 0, 0);
    q.delete();
    model(q);
    pad_pulse();
    consume(0);
    idle_chk();
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(8'(8'h30 + i));
    model(q);
    q2.delete();
    q2.push_back(q[0]);
    q2.push_back(q[1]);
    send(q2, 0, 0, 0, 0);
    pad_pulse();
    chk("pad_ignored_cnt2", block_valid_o, 0);
    q2.delete();
    for (int i = 2; i < 5; i++) q2.push_back(q[i]);
    send(q2, 1, 1, 0, 0);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h50 + i));
    model(q);
    send(q, 1, 1, 0, 1);
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h60 + i));
    model(q);
    send(q, 1, 1, 5, 0);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h70 + i));
    send(q, 0, 0, 0, 0);
    do_reset();
    q.delete();
    q.push_back(8'hAA);
    model(q);
    send(q, 1, 1, 0, 0);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'(8'h90 + i));
    model(q);
    send(q, 1, 0, 0, 0);
    consume(0);
    chk("padx_data", block_o, 64'h8000_0000_0000_0000);
    chk("padx_last", block_last_o, 1);
    do_reset();
    q.delete();
    q.push_back(8'hAA);
    model(q);
    send(q, 1, 1, 0, 0);
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(0, 20);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      model(q);
      if (len == 0) begin
        pad_pulse();
        consume($urandom_range(0, 3));
        idle_chk();
      end else send(q, 1, 1, $urandom_range(0, 3), 0);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
